// File: rtl/pix_pack_pkg.sv
// Shared widths and helpers for the 16->64 bit pixel packing FIFO.
// The FIFO packs halfwords into words and buffers the words for the DDR write master.
package pix_pack_pkg;

  localparam int PACK_RATIO = 4;
  localparam int HW_W       = 16;
  localparam int WORD_W     = HW_W * PACK_RATIO;
  localparam int PTR_W      = 8;
  localparam int CNT_W      = PTR_W + 1;
  localparam int PACK_W     = 2;
  localparam int WL_W       = CNT_W + PACK_W;

  // Halfword fill level: complete words times four plus the partial pack.
  function automatic logic [WL_W-1:0] calc_wr_level(input logic [CNT_W-1:0] count,
                                                     input logic [PACK_W-1:0] pack_cnt);
    return {count, pack_cnt};
  endfunction

endpackage

// File: rtl/pix_pack_ram.sv
// Simple dual-port word store with a registered, enable-gated read port.
// The read register clears on reset and on the synchronous clear.
module pix_pack_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/pix_pack_fifo.sv
// Write-side FIFO: packs four 16-bit pixel halfwords per 64-bit word and
// buffers the words for the DDR write master.
module pix_pack_fifo
  import pix_pack_pkg::*;
#(
  parameter int WR_DATA_WIDTH    = HW_W,
  parameter int RD_DATA_WIDTH    = WORD_W,
  parameter int RD_DEPTH_WIDTH   = PTR_W,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [WR_DATA_WIDTH-1:0]    wr_data,
  input  logic                        wr_en,
  output logic                        wr_full,
  output logic [RD_DEPTH_WIDTH+2:0]   wr_water_level,
  output logic                        almost_full,
  output logic [RD_DATA_WIDTH-1:0]    rd_data,
  input  logic                        rd_en,
  output logic                        rd_empty,
  output logic [RD_DEPTH_WIDTH:0]     rd_water_level,
  output logic                        almost_empty
);

  localparam int CW = RD_DEPTH_WIDTH + 1;
  localparam int WL = RD_DEPTH_WIDTH + 3;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(1) << RD_DEPTH_WIDTH;

  logic [RD_DEPTH_WIDTH-1:0]      wr_ptr_r;
  logic [RD_DEPTH_WIDTH-1:0]      rd_ptr_r;
  logic [CW-1:0]                  count_r;
  logic [CW-1:0]                  count_nxt_s;
  logic [1:0]                     pack_cnt_r;
  logic [3*WR_DATA_WIDTH-1:0]     packer_r;
  logic                           wr_acc_s;
  logic                           rd_acc_s;
  logic                           push_s;

  assign wr_full        = (count_r == DEPTH_CNT) && (pack_cnt_r == 2'd3);
  assign rd_empty       = (count_r == CW'(0));
  assign wr_water_level = calc_wr_level(count_r, pack_cnt_r);
  assign rd_water_level = count_r;
  assign almost_full    = (wr_water_level >= WL'(ALMOST_FULL_NUM));
  assign almost_empty   = (count_r <= CW'(ALMOST_EMPTY_NUM));

  // flush gates both strobes so it wins over any same-cycle access
  assign wr_acc_s = wr_en && !wr_full && !flush;
  assign rd_acc_s = rd_en && !rd_empty && !flush;
  assign push_s   = wr_acc_s && (pack_cnt_r == 2'd3);

  // Word count next-state: a push and a read in the same cycle cancel
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, counters and halfword packer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      pack_cnt_r <= 2'd0;
      packer_r   <= '0;
    end else if (flush) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      pack_cnt_r <= 2'd0;
      packer_r   <= '0;
    end else begin
      count_r <= count_nxt_s;
      if (wr_acc_s) begin
        pack_cnt_r <= pack_cnt_r + 2'd1;
        case (pack_cnt_r)
          2'd0:    packer_r[WR_DATA_WIDTH-1:0]                 <= wr_data;
          2'd1:    packer_r[2*WR_DATA_WIDTH-1:WR_DATA_WIDTH]   <= wr_data;
          2'd2:    packer_r[3*WR_DATA_WIDTH-1:2*WR_DATA_WIDTH] <= wr_data;
          default: wr_ptr_r <= wr_ptr_r + RD_DEPTH_WIDTH'(1);
        endcase
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + RD_DEPTH_WIDTH'(1);
      end
    end
  end

  pix_pack_ram #(
    .DATA_W (RD_DATA_WIDTH),
    .ADDR_W (RD_DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({wr_data, packer_r}),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_pix_pack_fifo.sv
// Directed self-checking bench for pix_pack_fifo.
module tb_pix_pack_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic [10:0] wr_water_level;
  logic        almost_full;
  logic [63:0] rd_data;
  logic        rd_en;
  logic        rd_empty;
  logic [8:0]  rd_water_level;
  logic        almost_empty;

  int checks = 0;
  int errors = 0;

  pix_pack_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 64'(rd_empty), 64'd1);
    chk({tag, "_ae"},    64'(almost_empty), 64'd1);
    chk({tag, "_full"},  64'(wr_full), 64'd0);
    chk({tag, "_af"},    64'(almost_full), 64'd0);
    chk({tag, "_wl"},    64'(wr_water_level), 64'd0);
    chk({tag, "_rdwl"},  64'(rd_water_level), 64'd0);
    chk({tag, "_rdata"}, rd_data, 64'd0);
  endtask

  logic [63:0] exp_w;

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 16'h0000;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_reset_state("reset");

    // first group of four halfwords
    wr_en = 1'b1;
    wr_data = 16'h0001; step();
    wr_data = 16'h0002; step();
    wr_data = 16'h0003; step();
    chk("pre4_empty", 64'(rd_empty), 64'd1);
    chk("pre4_wl", 64'(wr_water_level), 64'd3);
    chk("pre4_rdwl", 64'(rd_water_level), 64'd0);
    wr_data = 16'h0004; step();
    wr_en = 1'b0;
    chk("w4_rdwl", 64'(rd_water_level), 64'd1);
    chk("w4_empty", 64'(rd_empty), 64'd0);
    chk("w4_wl", 64'(wr_water_level), 64'd4);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("w4_rdata", rd_data, 64'h0004_0003_0002_0001);
    chk("w4_empty_after", 64'(rd_empty), 64'd1);

    // fill to full, then one dropped write
    wr_en = 1'b1;
    for (int i = 0; i < 1028; i++) begin
      wr_data = 16'(i);
      step();
      if (i == 1018) chk("af_1019", 64'(almost_full), 64'd0);
      if (i == 1019) begin
        chk("af_1020", 64'(almost_full), 64'd1);
        chk("wl_1020", 64'(wr_water_level), 64'd1020);
      end
      if (i == 1025) chk("full_1026", 64'(wr_full), 64'd0);
      if (i == 1026) begin
        chk("full_1027", 64'(wr_full), 64'd1);
        chk("wl_1027", 64'(wr_water_level), 64'd1027);
      end
      if (i == 1027) begin
        chk("drop_full", 64'(wr_full), 64'd1);
        chk("drop_wl", 64'(wr_water_level), 64'd1027);
        chk("drop_rdwl", 64'(rd_water_level), 64'd256);
      end
    end
    wr_en = 1'b0;

    // drain all 256 words
    rd_en = 1'b1;
    step();
    chk("rd_clears_full", 64'(wr_full), 64'd0);
    chk("drain_first", rd_data, 64'h0003_0002_0001_0000);
    chk("drain_first_rdwl", 64'(rd_water_level), 64'd255);
    for (int k = 1; k < 256; k++) begin
      step();
      exp_w = {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
      chk("drain_data", rd_data, exp_w);
      chk("drain_ae", 64'(almost_empty), ((255 - k) <= 4) ? 64'd1 : 64'd0);
    end
    step();
    rd_en = 1'b0;
    chk("empty_rd_hold", rd_data, 64'h03FF_03FE_03FD_03FC);
    chk("empty_rd_rdwl", 64'(rd_water_level), 64'd0);
    chk("empty_rd_empty", 64'(rd_empty), 64'd1);

    // simultaneous word push and read with count=10, pack_cnt=3
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush1_wl", 64'(wr_water_level), 64'd0);
    chk("flush1_rdata", rd_data, 64'd0);
    chk("flush1_full", 64'(wr_full), 64'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 43; i++) begin
      wr_data = 16'h0100 + 16'(i);
      step();
    end
    chk("pre_sim_rdwl", 64'(rd_water_level), 64'd10);
    chk("pre_sim_wl", 64'(wr_water_level), 64'd43);
    wr_data = 16'h0BEE;
    rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("sim_rdwl", 64'(rd_water_level), 64'd10);
    chk("sim_wl", 64'(wr_water_level), 64'd40);
    chk("sim_rdata", rd_data, 64'h0103_0102_0101_0100);

    // flush with count=5, pack_cnt=2 and a same-cycle write
    flush = 1'b1; step(); flush = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wr_data = 16'h0200 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("pre_fl_rdata", rd_data, 64'h0203_0202_0201_0200);
    chk("pre_fl_rdwl", 64'(rd_water_level), 64'd5);
    wr_en = 1'b1;
    wr_data = 16'h0220; step();
    wr_data = 16'h0221; step();
    chk("pre_fl_wl", 64'(wr_water_level), 64'd22);
    wr_data = 16'h0FFF;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk_reset_state("flush");
    step();
    chk("flush_drop_wl", 64'(wr_water_level), 64'd0);

    // asynchronous reset in the middle of a burst
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 16'h0300 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("pre_rst_rdata", rd_data, 64'h0303_0302_0301_0300);
    wr_en = 1'b1;
    wr_data = 16'h0310; step();
    wr_data = 16'h0311; step();
    chk("pre_rst_wl", 64'(wr_water_level), 64'd6);
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    wr_en = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_wl", 64'(wr_water_level), 64'd0);
    chk("post_rst_empty", 64'(rd_empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
